// File: rtl/dynamic_branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: counter encodings,
// weak-state initialisation helpers and the PC-to-index slice.
package branch_predictor_pkg;

  // Named states of a 2-bit saturating counter (all-ones is strongest taken).
  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } counter2_e;

  // Weakly-taken value for a counter of the given width: 100..0.
  function automatic logic [31:0] weak_taken_init(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Weakly-not-taken value for a counter of the given width: 011..1.
  function automatic logic [31:0] weak_not_taken_init(input int unsigned bits);
    return weak_taken_init(bits) - 32'd1;
  endfunction

  // Table index from the PC: drops the two byte-offset bits, keeps 'bits' bits.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned bits);
    return (pc >> 2) & ((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/dynamic_branch_predictor_saturating_counter_update.sv
// Combinational next-counter value for one predictor entry on resolution.
module saturating_counter_update
  import branch_predictor_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic [COUNTER_BITS-1:0] counter,
  input  logic                    valid,
  input  logic                    taken,
  output logic [COUNTER_BITS-1:0] next_counter
);

  localparam logic [COUNTER_BITS-1:0] WEAK_T_INIT  = COUNTER_BITS'(weak_taken_init(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0] WEAK_NT_INIT = COUNTER_BITS'(weak_not_taken_init(COUNTER_BITS));

  // Untrained entries start weak in the resolved direction; trained ones saturate.
  always_comb begin
    next_counter = counter;
    if (!valid) begin
      next_counter = taken ? WEAK_T_INIT : WEAK_NT_INIT;
    end else if (taken) begin
      if (counter != '1) next_counter = counter + COUNTER_BITS'(1);
    end else begin
      if (counter != '0) next_counter = counter - COUNTER_BITS'(1);
    end
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Dynamic branch predictor: table of saturating counters indexed by PC,
// trained on branch resolution, with static BTFN fallback for untrained entries.
// Optional global-history index hashing under macro BP_GSHARE_EN.
module dynamic_branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       pc_plus_four,
  input  logic [XLEN-1:0]       immediate,
  input  logic                  jump,
  input  logic                  branch,
  output logic [XLEN-1:0]       branch_target,
  output logic                  branch_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]      valid_q;
  logic [COUNTER_BITS-1:0] counters [ENTRIES];
  logic [COUNTER_BITS-1:0] next_counter;
  logic [INDEX_BITS-1:0]   pc_idx;

  assign pc_idx = INDEX_BITS'(pc_index(64'(pc), INDEX_BITS));

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // Global history shifts in each accepted resolution.
  always_ff @(posedge clk) begin
    if (reset) ghr <= '0;
    else if (update_valid) ghr <= {ghr[INDEX_BITS-2:0], update_taken};
  end

  assign predict_index = pc_idx ^ ghr;
`else
  assign predict_index = pc_idx;
`endif

  assign branch_target = pc_plus_four + immediate;

  // Jump beats branch; untrained entries fall back to backward-taken.
  always_comb begin
    branch_taken = 1'b0;
    if (jump) begin
      branch_taken = 1'b1;
    end else if (branch) begin
      if (valid_q[predict_index]) branch_taken = counters[predict_index][COUNTER_BITS-1];
      else                        branch_taken = immediate[XLEN-1];
    end
  end

  saturating_counter_update #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_counter_update (
    .counter      (counters[update_index]),
    .valid        (valid_q[update_index]),
    .taken        (update_taken),
    .next_counter (next_counter)
  );

  // Valid bits clear on reset; reset overrides a concurrent update.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (update_valid) valid_q[update_index] <= 1'b1;
  end

  // Counter storage has no reset; an entry is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset && update_valid) counters[update_index] <= next_counter;
  end

endmodule
